// File: rtl/neuron_mac.sv
// Q8.8 dot product of N_INPUTS x/w pairs plus bias, saturated to Q8.8; done rises 2 edges after the last accepted pair.
// Backpressure: pairs are accepted only while in_ready is high (ACC state), and in_valid gaps are allowed.
module neuron_mac #(
   parameter int N_INPUTS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [15:0] x_in,
   input  logic [15:0] w_in,
   input  logic [15:0] bias,
   output logic        in_ready,
   output logic [15:0] mac_out,
   output logic        done,
   output logic        busy
);

   localparam int ACC_W = 40;
   localparam int CNT_W = $clog2(N_INPUTS + 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
   localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

   typedef enum logic [2:0] {IDLE, ACC, BIAS, SAT, DONE} state_t;

   state_t                   state, state_nxt;
   logic signed [ACC_W-1:0]  acc;
   logic        [CNT_W-1:0]  beat_cnt;
   logic signed [31:0]       prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  bias_ext;
   logic signed [ACC_W-1:0]  acc_shr;
   logic        [15:0]       sat_val;
   logic                     accept;
   logic                     last_beat;

   assign prod      = $signed(x_in) * $signed(w_in);
   assign prod_ext  = {{(ACC_W-32){prod[31]}}, prod};
   // bias is Q8.8; shift by 8 to line up with the Q16.16 products
   assign bias_ext  = {{(ACC_W-24){bias[15]}}, bias, 8'h00};
   assign acc_shr   = acc >>> 8;
   assign in_ready  = (state == ACC);
   assign accept    = in_ready && in_valid;
   assign last_beat = (beat_cnt == CNT_W'(N_INPUTS - 1));
   assign busy      = (state == ACC) || (state == BIAS) || (state == SAT);
   assign done      = (state == DONE);

   always_comb begin
      sat_val = acc_shr[15:0];
      if (acc_shr > SAT_MAX)
         sat_val = 16'h7FFF;
      else if (acc_shr < SAT_MIN)
         sat_val = 16'h8000;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ACC;
         ACC:     if (accept && last_beat) state_nxt = BIAS;
         BIAS:    state_nxt = SAT;
         SAT:     state_nxt = DONE;
         DONE:    if (start) state_nxt = ACC;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc      <= '0;
         beat_cnt <= '0;
         mac_out  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  acc      <= '0;
                  beat_cnt <= '0;
               end
            end
            ACC: begin
               if (accept) begin
                  acc      <= acc + prod_ext;
                  beat_cnt <= beat_cnt + CNT_W'(1);
               end
            end
            BIAS:    acc     <= acc + bias_ext;
            SAT:     mac_out <= sat_val;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with N_INPUTS=4: arithmetic, saturation, gaps, start-in-ACC and mid-operation reset.
module tb_neuron_mac;

   logic        clk;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [15:0] x_in;
   logic [15:0] w_in;
   logic [15:0] bias;
   logic        in_ready;
   logic [15:0] mac_out;
   logic        done;
   logic        busy;

   int checks = 0;
   int errors = 0;

   neuron_mac #(.N_INPUTS(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_valid (in_valid),
      .x_in     (x_in),
      .w_in     (w_in),
      .bias     (bias),
      .in_ready (in_ready),
      .mac_out  (mac_out),
      .done     (done),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation from IDLE/DONE; gap inserts an idle cycle between beats,
   // start_acc holds start high through ACC, prev is the mac_out that must be held.
   task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] w,
                         input logic [15:0] b, input logic [15:0] exp_out,
                         input bit gap, input bit start_acc, input logic [15:0] prev);
      bias  = b;
      start = 1'b1;
      tick();
      start = start_acc;
      chk({tag, "_ready_acc"}, 16'(in_ready), 16'd1);
      chk({tag, "_busy_acc"}, 16'(busy), 16'd1);
      chk({tag, "_done_clr"}, 16'(done), 16'd0);
      chk({tag, "_hold_old"}, mac_out, prev);
      for (int i = 0; i < 4; i++) begin
         if (gap && i > 0) begin
            in_valid = 1'b0;
            tick();
            chk({tag, "_gap_ready"}, 16'(in_ready), 16'd1);
         end
         in_valid = 1'b1;
         x_in     = x;
         w_in     = w;
         tick();
         in_valid = 1'b0;
      end
      start = 1'b0;
      chk({tag, "_ready_off"}, 16'(in_ready), 16'd0);
      chk({tag, "_busy_bias"}, 16'(busy), 16'd1);
      tick();
      chk({tag, "_done_early"}, 16'(done), 16'd0);
      tick();
      chk({tag, "_done"}, 16'(done), 16'd1);
      chk({tag, "_busy_done"}, 16'(busy), 16'd0);
      chk({tag, "_mac_out"}, mac_out, exp_out);
      tick();
      chk({tag, "_stable"}, mac_out, exp_out);
      chk({tag, "_done_hold"}, 16'(done), 16'd1);
   endtask

   initial begin
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      x_in     = '0;
      w_in     = '0;
      bias     = '0;
      #12;
      chk("rst_mac_out", mac_out, 16'h0000);
      chk("rst_done", 16'(done), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_ready", 16'(in_ready), 16'd0);
      reset = 1'b1;
      tick();
      chk("idle_ready", 16'(in_ready), 16'd0);
      // in_valid while IDLE must be ignored
      in_valid = 1'b1;
      x_in     = 16'h7FFF;
      w_in     = 16'h7FFF;
      tick();
      in_valid = 1'b0;
      chk("idle_busy", 16'(busy), 16'd0);

      // 4 * (1.0 * 0.5) = 2.0
      run_op("half", 16'h0100, 16'h0080, 16'h0000, 16'h0200, 1'b0, 1'b0, 16'h0000);
      // 4 * (1.0 * -1.0) + 0.5 = -3.5
      run_op("neg", 16'h0100, 16'hFF00, 16'h0080, 16'hFC80, 1'b0, 1'b0, 16'h0200);
      run_op("sat_pos", 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b0, 1'b0, 16'hFC80);
      run_op("sat_neg", 16'h8000, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 16'h7FFF);
      // sum of products = -4 LSB of Q16.16; shift floors to -1 LSB of Q8.8
      run_op("floor", 16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'h8000);
      run_op("gaps", 16'h0100, 16'h0080, 16'h0000, 16'h0200, 1'b1, 1'b0, 16'hFFFF);
      run_op("start_acc", 16'h0100, 16'hFF00, 16'h0080, 16'hFC80, 1'b1, 1'b1, 16'h0200);

      // reset after two accepted beats
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         x_in     = 16'h7FFF;
         w_in     = 16'h7FFF;
         tick();
      end
      in_valid = 1'b0;
      chk("pre_rst_busy", 16'(busy), 16'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_ready", 16'(in_ready), 16'd0);
      chk("mid_rst_busy", 16'(busy), 16'd0);
      chk("mid_rst_done", 16'(done), 16'd0);
      chk("mid_rst_mac", mac_out, 16'h0000);
      tick();
      #3;
      reset = 1'b1;
      tick();
      chk("post_rst_idle", 16'(busy), 16'd0);
      run_op("fresh", 16'h0100, 16'h0080, 16'h0000, 16'h0200, 1'b0, 1'b0, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL provide parameter N_INPUTS, default 8, number of input/weight pairs per dot product (2..256).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  reset, asynchronous and active-low: reset=0 forces the reset state immediately, independent of clk.
REQ-004 SHALL provide port start  input  1  request to begin a new dot product; sampled in IDLE only.
REQ-005 SHALL provide port in_valid  input  1  x_in/w_in carry a valid pair this cycle.
REQ-006 SHALL provide port x_in  input  16  signed Q8.8 activation.
REQ-007 SHALL provide port w_in  input  16  signed Q8.8 weight.
REQ-008 SHALL provide port bias  input  16  signed Q8.8 bias; sampled in BIAS state.
REQ-009 SHALL provide port in_ready  output  1  block accepts a pair this cycle.
REQ-010 SHALL provide port mac_out  output  16  signed Q8.8 saturated result; drives the sigmoid stage's sig_in.
REQ-011 SHALL provide port done  output  1  mac_out valid; drives the sigmoid stage's done.
REQ-012 SHALL provide port busy  output  1  high in any state other than IDLE and DONE.

Function
REQ-013 SHALL implement FSM states IDLE, ACC, BIAS, SAT, DONE.
REQ-014 SHALL transition IDLE->ACC on a rising edge with start=1, and clear the accumulator and beat counter on that edge.
REQ-015 SHALL drive in_ready=1 only in ACC; a beat is accepted on an edge where in_valid=1 and in_ready=1.
REQ-016 SHALL, on each accepted beat, form the full 32-bit signed product x_in*w_in (Q16.16) and add it, sign-extended, into a 40-bit signed accumulator, then increment the beat counter.
REQ-017 SHALL ignore in_valid when in_ready=0, and SHALL NOT change the accumulator or counter in ACC cycles without a handshake (gaps allowed).
REQ-018 SHALL transition ACC->BIAS on the edge that accepts beat number N_INPUTS.
REQ-019 SHALL, in BIAS, add bias sign-extended and shifted left 8 (Q16.16 alignment) into the accumulator, then go to SAT.
REQ-020 SHALL, in SAT, compute acc arithmetically shifted right 8 (truncation toward minus infinity), saturate it to 0x7FFF if >32767 or to 0x8000 if <-32768, register it into mac_out, and go to DONE.
REQ-021 SHALL assert done=1 in DONE, so done rises on the 2nd edge after the edge that accepts the last beat; mac_out SHALL be stable while done=1.
REQ-022 SHALL hold DONE until start=1, then clear done and go to ACC with the same actions as REQ-014; mac_out SHALL retain the old value until the next SAT.
REQ-023 SHALL ignore start in ACC, BIAS and SAT.
REQ-024 SHALL keep the accumulator wide enough that N_INPUTS<=256 worst-case products never wrap before saturation.

Reset
REQ-025 SHALL, while reset=0, force state=IDLE, accumulator=0, counter=0, mac_out=0x0000, done=0, in_ready=0, busy=0.
REQ-026 SHALL abort any operation in progress on reset assertion, with no partial result retained; the first edge after reset release behaves as IDLE.

Verification
REQ-027 SHALL verify: N_INPUTS=4, x_in=0x0100, w_in=0x0080 on all beats, bias=0x0000 -> mac_out=0x0200, done rises 2 edges after the 4th accept.
REQ-028 SHALL verify: N_INPUTS=4, x_in=0x0100, w_in=0xFF00 on all beats, bias=0x0080 -> mac_out=0xFC80 (-3.5).
REQ-029 SHALL verify saturation: x_in=0x7FFF, w_in=0x7FFF x4 -> mac_out=0x7FFF; x_in=0x8000, w_in=0x7FFF x4 -> mac_out=0x8000.
REQ-030 SHALL verify gaps: the scenario of REQ-027 with in_valid low one cycle between beats -> same 0x0200, with the counter advancing on handshakes only.
REQ-031 SHALL verify reset mid-operation: reset=0 after 2 accepted beats -> in_ready, busy, done and mac_out are 0 immediately; a following start plus 4 beats gives a fresh correct result.
REQ-032 SHALL verify that start=1 pulsed during ACC has no effect on the result or the beat count.
